// File: rtl/lpc_sched_pkg.sv
// Shared definitions for the LPC frame scheduler: FSM state encoding, error codes, default watchdog limit.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package lpc_sched_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ACORR = 3'd1;
   localparam logic [2:0] ST_LEV   = 3'd2;
   localparam logic [2:0] ST_IFILT = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_OVERRUN  = 2'd1;
   localparam logic [1:0] ERR_UNSTABLE = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   localparam int TIMEOUT_DEFAULT = 65535;

   // States in which a pipeline stage is running and the watchdog is armed.
   function automatic logic is_stage_state(input logic [2:0] st);
      return (st == ST_ACORR) || (st == ST_LEV) || (st == ST_IFILT);
   endfunction

endpackage

// File: rtl/lpc_watchdog.sv
// Stage watchdog: counts cycles while enabled and flags expiry once TIMEOUT cycles have been spent.
// Latency: expired is combinational on the current count; the clear takes effect on the next cycle.
// Backpressure: none; the counter holds at the limit until cleared.
module lpc_watchdog #(
   parameter int TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt;

   // The cycle in which cnt equals TIMEOUT-1 is the TIMEOUT-th cycle in the state, so that is the last one allowed.
   assign expired = en && (cnt >= W'(TIMEOUT - 1));

   // Cycle counter: cleared on every state change, advances only while a stage is running.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/lpc_frame_scheduler.sv
// Frame sequencer for the LPC encoder (autocorr -> Levinson -> inverse filter) over a two-bank ping-pong buffer.
// Latency: stage start pulses one cycle after the triggering done/full; acorr_start 2 cycles after res_ack when a bank waits.
// Backpressure: frame_ready drops when the load bank is still full; residue held until res_ack. Option: LPC_SCHED_PERF_EN.
module lpc_frame_scheduler
   import lpc_sched_pkg::*;
#(
   parameter int FRAME_LEN = 256,
   parameter int TIMEOUT   = TIMEOUT_DEFAULT,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_valid,
   output logic             frame_ready,
   output logic             load_bank,
   output logic             proc_bank,
   output logic             acorr_start,
   input  logic             acorr_done,
   output logic             lev_start,
   input  logic             lev_done,
   input  logic             lev_error,
   output logic             if_start,
   input  logic             if_done,
   output logic             res_valid,
   input  logic             res_ack,
   output logic             busy,
   output logic             err,
   output logic [1:0]       err_code,
   input  logic             err_clr,
   output logic [CNT_W-1:0] frame_count
`ifdef LPC_SCHED_PERF_EN
   ,
   output logic [31:0]      frame_cycles
`endif
);

   // FRAME_LEN is addressing information owned by the loader; only sanity-checked here.
   if (FRAME_LEN < 1 || TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
      $error("lpc_frame_scheduler: FRAME_LEN, TIMEOUT and CNT_W must be positive");
   end

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [1:0] full;
   logic [1:0] full_nx;
   logic       release_bank;
   logic       timeout_hit;
   logic       unstable_hit;
   logic       load_accept;
   logic       overrun;
   logic       wd_expired;

   assign frame_ready = ~full[load_bank];
   assign load_accept = frame_valid & frame_ready;
   assign overrun     = frame_valid & ~frame_ready;
   assign busy        = (state != ST_IDLE);

   lpc_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (state_nx != state),
      .en      (is_stage_state(state)),
      .expired (wd_expired)
   );

   // Next-state decode; the watchdog wins over a done pulse landing in the same cycle.
   always_comb begin
      state_nx     = state;
      release_bank = 1'b0;
      timeout_hit  = 1'b0;
      unstable_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (full[proc_bank]) state_nx = ST_ACORR;
         end
         ST_ACORR: begin
            if (wd_expired) begin
               state_nx = ST_IDLE; release_bank = 1'b1; timeout_hit = 1'b1;
            end else if (acorr_done) begin
               state_nx = ST_LEV;
            end
         end
         ST_LEV: begin
            if (wd_expired) begin
               state_nx = ST_IDLE; release_bank = 1'b1; timeout_hit = 1'b1;
            end else if (lev_done && lev_error) begin
               state_nx = ST_IDLE; release_bank = 1'b1; unstable_hit = 1'b1;
            end else if (lev_done) begin
               state_nx = ST_IFILT;
            end
         end
         ST_IFILT: begin
            if (wd_expired) begin
               state_nx = ST_IDLE; release_bank = 1'b1; timeout_hit = 1'b1;
            end else if (if_done) begin
               state_nx = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (res_ack) begin
               state_nx = ST_IDLE; release_bank = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Bank occupancy: a release and a load in one cycle always hit different banks, so both apply.
   always_comb begin
      full_nx = full;
      if (release_bank) full_nx[proc_bank] = 1'b0;
      if (load_accept)  full_nx[load_bank] = 1'b1;
   end

   // FSM state, bank pointers and the completed/aborted frame counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         full        <= 2'b00;
         load_bank   <= 1'b0;
         proc_bank   <= 1'b0;
         frame_count <= '0;
      end else begin
         state <= state_nx;
         full  <= full_nx;
         if (load_accept)  load_bank <= ~load_bank;
         if (release_bank) begin
            proc_bank   <= ~proc_bank;
            frame_count <= frame_count + CNT_W'(1);
         end
      end
   end

   // Start pulses fire in the first cycle of each stage state; res_valid tracks the HOLD state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acorr_start <= 1'b0;
         lev_start   <= 1'b0;
         if_start    <= 1'b0;
         res_valid   <= 1'b0;
      end else begin
         acorr_start <= (state_nx == ST_ACORR) && (state != ST_ACORR);
         lev_start   <= (state_nx == ST_LEV)   && (state != ST_LEV);
         if_start    <= (state_nx == ST_IFILT) && (state != ST_IFILT);
         res_valid   <= (state_nx == ST_HOLD);
      end
   end

   // Sticky error: timeout over unstable over overrun, and any new error beats err_clr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (timeout_hit) begin
         err      <= 1'b1;
         err_code <= ERR_TIMEOUT;
      end else if (unstable_hit) begin
         err      <= 1'b1;
         err_code <= ERR_UNSTABLE;
      end else if (overrun) begin
         err      <= 1'b1;
         err_code <= ERR_OVERRUN;
      end else if (err_clr) begin
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end
   end

`ifdef LPC_SCHED_PERF_EN
   logic [31:0] perf_cnt;

   // Cycles from the acorr_start cycle to the release cycle, saturating; latched when the bank is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_cnt     <= '0;
         frame_cycles <= '0;
      end else begin
         if (state == ST_IDLE && state_nx == ST_ACORR) begin
            perf_cnt <= '0;
         end else if (busy && perf_cnt != '1) begin
            perf_cnt <= perf_cnt + 32'd1;
         end
         if (release_bank) frame_cycles <= perf_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_lpc_frame_scheduler.sv
// Directed bench for lpc_frame_scheduler with a scoreboard of expected start order and frame counts.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Backpressure: every wait on a DUT event is bounded by a cycle budget.
module tb_lpc_frame_scheduler;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             frame_valid;
   logic             frame_ready;
   logic             load_bank;
   logic             proc_bank;
   logic             acorr_start;
   logic             acorr_done;
   logic             lev_start;
   logic             lev_done;
   logic             lev_error;
   logic             if_start;
   logic             if_done;
   logic             res_valid;
   logic             res_ack;
   logic             busy;
   logic             err;
   logic [1:0]       err_code;
   logic             err_clr;
   logic [CNT_W-1:0] frame_count;
`ifdef LPC_SCHED_PERF_EN
   logic [31:0]      frame_cycles;
`endif

   int total = 0;
   int bad   = 0;
   int start_q[$];
   int count_q[$];

   always #5 clk = ~clk;

   lpc_frame_scheduler #(
      .FRAME_LEN (256),
      .TIMEOUT   (32),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .load_bank   (load_bank),
      .proc_bank   (proc_bank),
      .acorr_start (acorr_start),
      .acorr_done  (acorr_done),
      .lev_start   (lev_start),
      .lev_done    (lev_done),
      .lev_error   (lev_error),
      .if_start    (if_start),
      .if_done     (if_done),
      .res_valid   (res_valid),
      .res_ack     (res_ack),
      .busy        (busy),
      .err         (err),
      .err_code    (err_code),
      .err_clr     (err_clr),
      .frame_count (frame_count)
`ifdef LPC_SCHED_PERF_EN
      ,
      .frame_cycles (frame_cycles)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for any start pulse; which=0 if no pulse occurs within the budget, 1 acorr, 2 lev, 3 inverse filter.
   task automatic wait_start(output int which, input int budget);
      which = 0;
      for (int i = 0; i < budget && which == 0; i++) begin
         if (acorr_start)    which = 1;
         else if (lev_start) which = 2;
         else if (if_start)  which = 3;
         if (which == 0) step();
      end
   endtask

   task automatic expect_start(input string tag);
      int w;
      int e;
      wait_start(w, 80);
      e = (start_q.size() > 0) ? start_q.pop_front() : -1;
      check(tag, w, e);
   endtask

   task automatic expect_count(input string tag);
      int e;
      e = (count_q.size() > 0) ? count_q.pop_front() : -1;
      check(tag, 32'(frame_count), e);
   endtask

   // Done pulse 10 cycles after the start seen in the current cycle: 1 acorr, 2 lev, 3 inverse filter.
   task automatic done_after10(input int sel, input logic lerr);
      repeat (10) step();
      case (sel)
         1: acorr_done = 1'b1;
         2: begin lev_done = 1'b1; lev_error = lerr; end
         default: if_done = 1'b1;
      endcase
      step();
      acorr_done = 1'b0;
      lev_done   = 1'b0;
      lev_error  = 1'b0;
      if_done    = 1'b0;
   endtask

   task automatic send_frame();
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
   endtask

   task automatic ack_residue();
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      int seen;
      reset       = 1'b0;
      frame_valid = 1'b0;
      acorr_done  = 1'b0;
      lev_done    = 1'b0;
      lev_error   = 1'b0;
      if_done     = 1'b0;
      res_ack     = 1'b0;
      err_clr     = 1'b0;
      repeat (2) step();

      // Reset values.
      check("rst_frame_ready", 32'(frame_ready), 1);
      check("rst_busy",        32'(busy), 0);
      check("rst_banks",       {30'd0, load_bank, proc_bank}, 0);
      check("rst_err",         {29'd0, err, err_code}, 0);
      check("rst_count",       32'(frame_count), 0);
      check("rst_outs",        {28'd0, acorr_start, lev_start, if_start, res_valid}, 0);
      reset = 1'b1;
      step();

      // Nominal frame.
      send_frame();
      check("t1_load_bank", 32'(load_bank), 1);
      start_q.push_back(1); start_q.push_back(2); start_q.push_back(3);
      expect_start("t1_start_acorr");
      step();
      check("t1_acorr_pulse_width", 32'(acorr_start), 0);
      repeat (9) step();
      acorr_done = 1'b1; step(); acorr_done = 1'b0;
      expect_start("t1_start_lev");
      done_after10(2, 1'b0);
      expect_start("t1_start_if");
      done_after10(3, 1'b0);
      check("t1_res_valid", 32'(res_valid), 1);
      check("t1_busy_hold", 32'(busy), 1);
      count_q.push_back(1);
      ack_residue();
      expect_count("t1_frame_count");
      check("t1_proc_bank", 32'(proc_bank), 1);
      check("t1_res_clear", {30'd0, res_valid, busy}, 0);
`ifdef LPC_SCHED_PERF_EN
      check("t6_frame_cycles", frame_cycles, 33);
`endif

      // Ping-pong with overrun, back-to-back start.
      do_reset();
      send_frame();
      start_q.push_back(1); start_q.push_back(2); start_q.push_back(3);
      expect_start("t2_start_acorr_a");
      send_frame();
      check("t2_load_bank", 32'(load_bank), 0);
      check("t2_frame_ready", 32'(frame_ready), 0);
      send_frame();
      check("t2_overrun", {30'd0, err_code}, 1);
      check("t2_overrun_err", 32'(err), 1);
      check("t2_drop_bank", {30'd0, load_bank, frame_ready}, 0);
      done_after10(1, 1'b0);
      expect_start("t2_start_lev_a");
      done_after10(2, 1'b0);
      expect_start("t2_start_if_a");
      done_after10(3, 1'b0);
      count_q.push_back(1);
      ack_residue();
      expect_count("t2_count_a");
      check("t2_b2b_gap", 32'(acorr_start), 0);
      step();
      check("t2_b2b_start", 32'(acorr_start), 1);
      check("t2_b2b_bank", 32'(proc_bank), 1);
      start_q.push_back(2); start_q.push_back(3);
      done_after10(1, 1'b0);
      expect_start("t2_start_lev_b");
      done_after10(2, 1'b0);
      expect_start("t2_start_if_b");
      done_after10(3, 1'b0);
      count_q.push_back(2);
      ack_residue();
      expect_count("t2_count_b");
      repeat (5) step();
      check("t2_dropped_idle", 32'(busy), 0);
      check("t2_ready_after", 32'(frame_ready), 1);
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("t2_err_clr", {29'd0, err, err_code}, 0);

      // Unstable Levinson solution.
      send_frame();
      start_q.push_back(1); start_q.push_back(2);
      expect_start("t3_start_acorr");
      done_after10(1, 1'b0);
      expect_start("t3_start_lev");
      done_after10(2, 1'b1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (if_start) seen++;
         step();
      end
      check("t3_no_if_start", seen, 0);
      check("t3_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd2});
      check("t3_frame_count", 32'(frame_count), 3);
      check("t3_proc_bank", 32'(proc_bank), 1);
      check("t3_idle", 32'(busy), 0);

      // Watchdog timeout in ACORR.
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("t4_err_cleared", 32'(err), 0);
      send_frame();
      start_q.push_back(1);
      expect_start("t4_start_acorr");
      repeat (31) step();
      check("t4_busy_before", 32'(busy), 1);
      step();
      check("t4_idle_at_32", 32'(busy), 0);
      check("t4_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd3});
      check("t4_frame_count", 32'(frame_count), 4);
      check("t4_proc_bank", 32'(proc_bank), 0);
      acorr_done = 1'b1; step(); acorr_done = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (acorr_start || lev_start || busy) seen++;
         step();
      end
      check("t4_late_done_ignored", seen, 0);
      check("t4_count_stable", 32'(frame_count), 4);

      // Asynchronous reset during IFILT.
      send_frame();
      send_frame();
      start_q.push_back(1); start_q.push_back(2); start_q.push_back(3);
      expect_start("t5_start_acorr");
      done_after10(1, 1'b0);
      expect_start("t5_start_lev");
      done_after10(2, 1'b0);
      expect_start("t5_start_if");
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_ready_busy", {30'd0, frame_ready, busy}, 32'd2);
      check("t5_rst_err", {29'd0, err, err_code}, 0);
      check("t5_rst_count", 32'(frame_count), 0);
      check("t5_rst_banks", {30'd0, load_bank, proc_bank}, 0);
      check("t5_rst_outs", {28'd0, acorr_start, lev_start, if_start, res_valid}, 0);
      #3;
      reset = 1'b1;
      repeat (4) step();
      check("t5_banks_empty", 32'(busy), 0);
      send_frame();
      send_frame();
      frame_valid = 1'b1;
      err_clr     = 1'b1;
      step();
      frame_valid = 1'b0;
      err_clr     = 1'b0;
      check("t5_clr_loses", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
      err_clr = 1'b1; step(); err_clr = 1'b0;
      check("t5_err_clr", {29'd0, err, err_code}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
